// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60), colour/coordinate widths and total-count helpers.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_R_W = 3;
  localparam int unsigned DEF_G_W = 3;
  localparam int unsigned DEF_B_W = 2;
  localparam int unsigned DEF_CW  = 11;

  // Raw timing flags carried through the renderer-latency delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } vga_flags_t;

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Width x depth shift register advancing on en, synchronously cleared (active-low) to CLR_VAL.
module vga_delay_line #(
  parameter int unsigned     WIDTH   = 1,
  parameter int unsigned     DEPTH   = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, en};
    assign q        = d;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= CLR_VAL;
      end else if (en) begin
        r_stage[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_frame_engine.sv
// VGA raster timing and registered pixel output engine on the board clock.
// Optional colour-bar generator enabled by macro VGA_TEST_PATTERN_EN.
module vga_frame_engine
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned PIX_DIV    = 4,
  parameter int unsigned RENDER_LAT = 2,
  parameter int unsigned R_W        = DEF_R_W,
  parameter int unsigned G_W        = DEF_G_W,
  parameter int unsigned B_W        = DEF_B_W,
  parameter int unsigned CW         = DEF_CW,
  parameter int unsigned FRAME_DIV  = 3
) (
  input  logic           clk,
  input  logic           rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic           test_en,
`endif
  input  logic [R_W-1:0] red_in,
  input  logic [G_W-1:0] green_in,
  input  logic [B_W-1:0] blue_in,
  output logic           pix_ce,
  output logic [CW-1:0]  pix_x,
  output logic [CW-1:0]  pix_y,
  output logic           pix_active,
  output logic [R_W-1:0] vga_r,
  output logic [G_W-1:0] vga_g,
  output logic [B_W-1:0] vga_b,
  output logic           sync_h,
  output logic           sync_v,
  output logic           vidon,
  output logic           frame_tick
);

  localparam int unsigned H_TOT  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOT  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;
  localparam int unsigned DIV_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned FDV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic             r_ce;
  logic [CW-1:0]    r_x, r_y, w_x_nxt, w_y_nxt;
  logic [FDV_W-1:0] r_fdiv;
  logic             r_tick;
  logic [R_W-1:0]   r_r, w_r;
  logic [G_W-1:0]   r_g, w_g;
  logic [B_W-1:0]   r_b, w_b;
  logic             r_hs, r_vs, r_von;
  logic             w_frame_wrap;
  vga_flags_t       w_flags_raw, w_flags_d;

  // Pixel strobe: registered so the first strobe lands PIX_DIV clks after reset release
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div <= '0;
      r_ce  <= 1'b0;
    end else begin
      r_ce  <= (r_div == DIV_W'(PIX_DIV - 1));
      r_div <= (r_div == DIV_W'(PIX_DIV - 1)) ? '0 : r_div + DIV_W'(1);
    end
  end

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (r_ce) begin
      if (r_x == CW'(H_TOT - 1)) begin
        w_x_nxt = '0;
        w_y_nxt = (r_y == CW'(V_TOT - 1)) ? '0 : r_y + CW'(1);
      end else begin
        w_x_nxt = r_x + CW'(1);
      end
    end
  end

  assign w_frame_wrap = r_ce && (r_x == CW'(H_TOT - 1)) && (r_y == CW'(V_TOT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_fdiv <= '0;
      r_tick <= 1'b0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_tick <= w_frame_wrap && (r_fdiv == FDV_W'(FRAME_DIV - 1));
      if (w_frame_wrap)
        r_fdiv <= (r_fdiv == FDV_W'(FRAME_DIV - 1)) ? '0 : r_fdiv + FDV_W'(1);
    end
  end

  assign w_flags_raw.hs  = (r_x >= CW'(HS_BEG)) && (r_x < CW'(HS_END));
  assign w_flags_raw.vs  = (r_y >= CW'(VS_BEG)) && (r_y < CW'(VS_END));
  assign w_flags_raw.act = (r_x < CW'(H_ACTIVE)) && (r_y < CW'(V_ACTIVE));

  vga_delay_line #(
    .WIDTH  ($bits(vga_flags_t)),
    .DEPTH  (RENDER_LAT),
    .CLR_VAL('0)
  ) u_flags_dly (
    .clk (clk),
    .rst (rst),
    .en  (r_ce),
    .d   (w_flags_raw),
    .q   (w_flags_d)
  );

`ifdef VGA_TEST_PATTERN_EN
  logic [CW-1:0] w_x_d;
  logic [2:0]    w_bar;

  vga_delay_line #(
    .WIDTH  (CW),
    .DEPTH  (RENDER_LAT),
    .CLR_VAL('0)
  ) u_x_dly (
    .clk (clk),
    .rst (rst),
    .en  (r_ce),
    .d   (r_x),
    .q   (w_x_d)
  );

  // Eight equal-width vertical bars indexed by the latency-aligned x
  always_comb begin
    w_bar = 3'(w_x_d / CW'(H_ACTIVE / 8));
    w_r   = red_in;
    w_g   = green_in;
    w_b   = blue_in;
    if (test_en) begin
      w_r = {R_W{w_bar[2]}};
      w_g = {G_W{w_bar[1]}};
      w_b = {B_W{w_bar[0]}};
    end
  end
`else
  always_comb begin
    w_r = red_in;
    w_g = green_in;
    w_b = blue_in;
  end
`endif

  // Pin registers: everything the monitor sees moves only on the strobe edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_r   <= '0;
      r_g   <= '0;
      r_b   <= '0;
      r_hs  <= ~SYNC_POL;
      r_vs  <= ~SYNC_POL;
      r_von <= 1'b0;
    end else if (r_ce) begin
      r_r   <= w_flags_d.act ? w_r : '0;
      r_g   <= w_flags_d.act ? w_g : '0;
      r_b   <= w_flags_d.act ? w_b : '0;
      r_hs  <= w_flags_d.hs ? SYNC_POL : ~SYNC_POL;
      r_vs  <= w_flags_d.vs ? SYNC_POL : ~SYNC_POL;
      r_von <= w_flags_d.act;
    end
  end

  assign pix_ce     = r_ce;
  assign pix_x      = r_x;
  assign pix_y      = r_y;
  assign pix_active = (r_x < CW'(H_ACTIVE)) && (r_y < CW'(V_ACTIVE));
  assign vga_r      = r_r;
  assign vga_g      = r_g;
  assign vga_b      = r_b;
  assign sync_h     = r_hs;
  assign sync_v     = r_vs;
  assign vidon      = r_von;
  assign frame_tick = r_tick;

endmodule
